// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial datapath adders.
// Holds the 2-bit state encoding used by the serial adder controller.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell.
// Purely combinational, zero latency, no flow control.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: X + Y + cin computed LSB-first through one full-adder cell.
// Latency WIDTH+1 cycles from accepted start to done; start ignored while busy, no queuing.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_nxt;

    full_adder u_fa (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Cin  (carry),
        .S    (fa_s),
        .Cout (fa_c)
    );

    // Sum bits enter from the MSB so after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_nxt = fa_s;
        end else begin : g_res_wn
            assign res_nxt = {fa_s, res_sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            S      <= '0;
            C      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= X;
                        b_sr  <= Y;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res_sr <= res_nxt;
                    carry  <= fa_c;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        // S/C only change here, so they survive a following operation.
                        S     <= res_nxt;
                        C     <= fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8, 1 and 13.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8 = 1'b1, start8 = 1'b0, cin8 = 1'b0, busy8, done8, C8;
    logic [7:0]  X8 = '0, Y8 = '0, S8;
    logic        rst1 = 1'b1, start1 = 1'b0, cin1 = 1'b0, busy1, done1, C1;
    logic [0:0]  X1 = '0, Y1 = '0, S1;
    logic        rst13 = 1'b1, start13 = 1'b0, cin13 = 1'b0, busy13, done13, C13;
    logic [12:0] X13 = '0, Y13 = '0, S13;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .X(X8), .Y(Y8), .cin(cin8),
        .busy(busy8), .done(done8), .S(S8), .C(C8)
    );
    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .X(X1), .Y(Y1), .cin(cin1),
        .busy(busy1), .done(done1), .S(S1), .C(C1)
    );
    serial_adder #(.WIDTH(13)) u_dut13 (
        .clk(clk), .rst(rst13), .start(start13), .X(X13), .Y(Y13), .cin(cin13),
        .busy(busy13), .done(done13), .S(S13), .C(C13)
    );

    logic [8:0]  q8[$];
    logic [1:0]  q1[$];
    logic [13:0] q13[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse, pushes the model result, then scrambles the operand pins.
    task automatic start_op(input int which, input logic [12:0] x, input logic [12:0] y, input logic c);
        case (which)
            1: begin
                X1 = x[0:0]; Y1 = y[0:0]; cin1 = c; start1 = 1'b1;
                q1.push_back(2'(x[0]) + 2'(y[0]) + 2'(c));
            end
            8: begin
                X8 = x[7:0]; Y8 = y[7:0]; cin8 = c; start8 = 1'b1;
                q8.push_back(9'(x[7:0]) + 9'(y[7:0]) + 9'(c));
            end
            default: begin
                X13 = x; Y13 = y; cin13 = c; start13 = 1'b1;
                q13.push_back(14'(x) + 14'(y) + 14'(c));
            end
        endcase
        tick();
        start1 = 1'b0; start8 = 1'b0; start13 = 1'b0;
        X1 = 1'($urandom); Y1 = 1'($urandom); cin1 = 1'($urandom);
        X8 = 8'($urandom); Y8 = 8'($urandom); cin8 = 1'($urandom);
        X13 = 13'($urandom); Y13 = 13'($urandom); cin13 = 1'($urandom);
    endtask

    // Called in cycle 1 after a start; returns the cycle index where done is seen.
    task automatic wait_done(input int which, output int cyc, output int bc, output int ovl);
        logic b, d;
        cyc = 1; bc = 0; ovl = 0;
        while (1) begin
            case (which)
                1:       begin b = busy1;  d = done1;  end
                8:       begin b = busy8;  d = done8;  end
                default: begin b = busy13; d = done13; end
            endcase
            if (b && d) ovl++;
            if (d || cyc >= 64) break;
            if (b) bc++;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst8 = 1'b1; rst1 = 1'b1; rst13 = 1'b1;
        tick(); tick();
        rst8 = 1'b0; rst1 = 1'b0; rst13 = 1'b0;
        vectors++;
        if ({busy8, done8, C8, S8} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_w8 busy/done/C/S got %b expected 0", {busy8, done8, C8, S8});
        end
        vectors++;
        if ({busy1, done1, C1, S1} !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_w1 busy/done/C/S got %b expected 0", {busy1, done1, C1, S1});
        end
        vectors++;
        if ({busy13, done13, C13, S13} !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_w13 busy/done/C/S got %b expected 0", {busy13, done13, C13, S13});
        end
        tick();
    endtask

    task automatic test_basic();
        int cyc, bc, ovl;
        logic [8:0] exp;
        start_op(8, 13'h3C, 13'h0F, 1'b0);
        wait_done(8, cyc, bc, ovl);
        exp = q8.pop_front();
        vectors++;
        if (cyc !== 9) begin miscompares++; $display("FAIL basic_latency got %0d expected 9", cyc); end
        vectors++;
        if (bc !== 8) begin miscompares++; $display("FAIL basic_busy_cycles got %0d expected 8", bc); end
        vectors++;
        if ({C8, S8} !== exp || exp !== 9'h04B) begin
            miscompares++; $display("FAIL basic_sum got C=%b S=%h expected %h", C8, S8, 9'h04B);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, bc, ovl;
        logic [8:0] exp;
        start_op(8, 13'hFF, 13'h01, 1'b0);
        wait_done(8, cyc, bc, ovl);
        exp = q8.pop_front();
        vectors++;
        if ({C8, S8} !== 9'h100 || exp !== 9'h100) begin
            miscompares++; $display("FAIL b2b_first got C=%b S=%h expected C=1 S=00", C8, S8);
        end
        // Still in the done cycle: this start must be accepted.
        start_op(8, 13'hA5, 13'h5A, 1'b1);
        vectors++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            miscompares++; $display("FAIL b2b_accept busy=%b done=%b expected busy=1 done=0", busy8, done8);
        end
        wait_done(8, cyc, bc, ovl);
        exp = q8.pop_front();
        vectors++;
        if (cyc !== 9) begin miscompares++; $display("FAIL b2b_latency got %0d expected 9", cyc); end
        vectors++;
        if ({C8, S8} !== exp) begin
            miscompares++; $display("FAIL b2b_second got C=%b S=%h expected %h", C8, S8, exp);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int cyc, bc, dn;
        logic [8:0] exp;
        start_op(8, 13'h10, 13'h20, 1'b0);
        cyc = 1; bc = 0;
        while (!done8 && cyc < 64) begin
            if (busy8) bc++;
            if (cyc == 4) begin start8 = 1'b1; X8 = 8'hFF; Y8 = 8'hFF; end
            else start8 = 1'b0;
            tick();
            cyc++;
        end
        start8 = 1'b0;
        exp = q8.pop_front();
        vectors++;
        if (cyc !== 9 || bc !== 8) begin
            miscompares++; $display("FAIL ignore_timing got done@%0d busy=%0d expected done@9 busy=8", cyc, bc);
        end
        vectors++;
        if ({C8, S8} !== exp || exp !== 9'h030) begin
            miscompares++; $display("FAIL ignore_sum got C=%b S=%h expected C=0 S=30", C8, S8);
        end
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) dn++;
        end
        vectors++;
        if (dn !== 0) begin miscompares++; $display("FAIL ignore_single_done got %0d extra busy/done cycles expected 0", dn); end
    endtask

    task automatic test_reset_abort();
        int cyc, bc, ovl, dn;
        logic [8:0] exp;
        start_op(8, 13'h80, 13'h80, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        void'(q8.pop_back());
        vectors++;
        if ({busy8, done8, C8, S8} !== 11'd0) begin
            miscompares++; $display("FAIL abort_state got busy/done/C/S %b expected 0", {busy8, done8, C8, S8});
        end
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) dn++;
            tick();
        end
        vectors++;
        if (dn !== 0) begin miscompares++; $display("FAIL abort_no_done got %0d done cycles expected 0", dn); end
        start_op(8, 13'h12, 13'h34, 1'b0);
        wait_done(8, cyc, bc, ovl);
        exp = q8.pop_front();
        vectors++;
        if (cyc !== 9 || {C8, S8} !== exp) begin
            miscompares++; $display("FAIL abort_restart got done@%0d C=%b S=%h expected done@9 %h", cyc, C8, S8, exp);
        end
        tick();
    endtask

    task automatic test_width1();
        int cyc, bc, ovl;
        logic [1:0] exp;
        start_op(1, 13'd1, 13'd1, 1'b1);
        wait_done(1, cyc, bc, ovl);
        exp = q1.pop_front();
        vectors++;
        if (cyc !== 2 || bc !== 1) begin
            miscompares++; $display("FAIL w1_timing got done@%0d busy=%0d expected done@2 busy=1", cyc, bc);
        end
        vectors++;
        if ({C1, S1} !== exp || exp !== 2'b11) begin
            miscompares++; $display("FAIL w1_sum_111 got C=%b S=%b expected C=1 S=1", C1, S1);
        end
        tick();
        start_op(1, 13'd0, 13'd1, 1'b0);
        wait_done(1, cyc, bc, ovl);
        exp = q1.pop_front();
        vectors++;
        if (cyc !== 2 || {C1, S1} !== exp) begin
            miscompares++; $display("FAIL w1_sum_010 got done@%0d C=%b S=%b expected done@2 %b", cyc, C1, S1, exp);
        end
        tick();
    endtask

    task automatic test_random(input int which, input int n);
        int cyc, bc, ovl, w;
        logic [13:0] exp, got;
        logic [12:0] msk;
        w = which;
        msk = (which == 8) ? 13'h00FF : 13'h1FFF;
        for (int k = 0; k < n; k++) begin
            start_op(which, 13'($urandom) & msk, 13'($urandom) & msk, 1'($urandom));
            wait_done(which, cyc, bc, ovl);
            if (which == 8) begin exp = 14'(q8.pop_front());  got = {5'd0, C8, S8}; end
            else            begin exp = q13.pop_front();      got = {C13, S13}; end
            vectors++;
            if (cyc !== w + 1 || bc !== w || ovl !== 0) begin
                miscompares++;
                $display("FAIL rand_w%0d_timing op %0d got done@%0d busy=%0d overlap=%0d expected done@%0d busy=%0d", w, k, cyc, bc, ovl, w + 1, w);
            end
            vectors++;
            if (got !== exp) begin
                miscompares++; $display("FAIL rand_w%0d_sum op %0d got %h expected %h", w, k, got, exp);
            end
            if ($urandom_range(1, 0) == 1) begin
                tick();
                vectors++;
                if ((which == 8 ? done8 : done13) !== 1'b0) begin
                    miscompares++; $display("FAIL rand_w%0d_done_width op %0d done still high, expected 0", w, k);
                end
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        test_width1();
        test_random(8, 1000);
        test_random(13, 1000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
